mips_multicycle_core: RTL and testbench
=======================================

// Module: mips_multicycle_core
// PURPOSE
// - Parametrised multi-cycle MIPS-subset core: fetch/decode/execute/writeback FSM with req/ack instruction-memory handshake.
// - Successor to the single-cycle top: PC advances only after an instruction retires, so a new fetch never overlaps execution.
// - Sits between the instruction ROM and the bench/debug harness; exposes PC, control word, register file and retire count.
// PARAMETERS
// - DATA_W   32  register/ALU width
// - PC_W     4   byte-address PC width (PC steps by 4, wraps modulo 2**PC_W)
// - NREGS    4   physical registers, power of 2, >=2
// - REG_BASE 16  architectural reg number mapped to index 0 ($s0)
// - CNT_W    8   retired-instruction counter width
// PORTS
// - clk           in   1              single clock, rising edge
// - rst           in   1              synchronous, active-low reset
// - enable        in   1              run; sampled only in S_IDLE
// - imem_req      out  1              fetch request
// - imem_addr     out  PC_W           fetch address (= pc)
// - imem_ack      in   1              instruction valid this cycle
// - imem_data     in   32             instruction word
// - reg_load      in   1              bulk-load register file (S_IDLE only)
// - reg_load_data in   NREGS*DATA_W   load data, index 0 in LSBs
// - pc            out  PC_W           current PC
// - control       out  4              {jump, reg_write, branch, rtype}
// - instruction   out  32             latched instruction
// - reg_flat      out  NREGS*DATA_W   register file contents
// - write_data    out  DATA_W         last ALU result
// - retired       out  CNT_W          instructions retired, wraps
// - illegal       out  1              sticky: unsupported opcode/funct seen
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-low.
// - Reset (rst==0 at edge): state=S_IDLE, pc=0, control=0, instruction=0, write_data=0, retired=0, illegal=0, imem_req=0, all regs=0.
// - States: S_IDLE -> S_FETCH (enable=1) -> S_DECODE -> S_EXEC -> S_WB -> S_FETCH (enable=1) or S_IDLE (enable=0).
// - S_IDLE: reg_load=1 writes reg_flat<=reg_load_data same edge; ignored in all other states.
// - S_FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on ack latch instruction, go S_DECODE. Any ack latency >=0 extra cycles legal.
// - imem_ack while imem_req=0 ignored.
// - S_DECODE: control from opcode: j(0x02)=4'b1000; R-type(0x00) funct add(0x20)/sub(0x22)/and(0x24)/or(0x25)=4'b0101; else 4'b0000, illegal<=1.
// - S_EXEC: ALU result mod 2**DATA_W (add/sub wrap, no overflow trap); write_data<=result.
// - S_WB: rd write if reg_write and rd in range; retired<=retired+1 (all instrs incl. illegal);
//   pc<=jump ? {instr[PC_W-3:0],2'b00} : pc+4 (wrap to 0).
// - Best-case CPI = 4 (ack in first fetch cycle).
// - Register map: index=r-REG_BASE; r outside [REG_BASE,REG_BASE+NREGS) reads 0, writes discarded (not illegal).
// - rd==rs/rt: operands read in S_EXEC, write in S_WB; no hazard possible.
// - Reset mid-fetch/exec: abort immediately, no register write, imem_req drops next cycle.
// - enable low mid-instruction: instruction completes, halts in S_IDLE after S_WB.
// CONFIGURATION
// - MIPS_CORE_BEQ_EN defined: beq(0x04) decodes control=4'b0010; S_EXEC compares rs==rt;
//   taken -> pc<=pc+4+{simm16,2'b00} (truncated to PC_W), else pc+4.
// - Undefined: beq treated as unsupported: control=0, illegal<=1, pc<=pc+4.
// TESTING
// - Reset: rst=0 two cycles mid-S_EXEC -> all outputs reset values, imem_req=0, state S_IDLE.
// - Program: preload {3,27,111,1}; ROM[0]=0x08000002 (j), [4]=0x02508020, [8]=0x02118020, [12]=0x02328020, enable=1, ack immediate
//   -> pc 0,8,12; control 1000,0101,0101; $s0=112 then 138; [4] never fetched; retired=3.
// - Slow memory: ack 5 cycles after req -> imem_addr stable while req high, CPI=9, same results.
// - Out-of-range: add $t0,$s1,$s2 (rd=8) -> write_data=138, reg_flat unchanged, illegal=0.
// - Illegal: word 0xFC000000 -> control=0000, illegal=1 sticky, pc+=4, retired+1.
// - BEQ (MIPS_CORE_BEQ_EN): beq $s0,$s0,-2 at pc=8 -> pc=4; without macro illegal=1, pc=12.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: IDLE/FETCH/DECODE/EXEC/WB FSM with a req/ack instruction fetch.
// Define MIPS_CORE_BEQ_EN to add beq; without it beq decodes as an unsupported opcode.
module mips_multicycle_core #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 4,
    parameter int NREGS    = 4,
    parameter int REG_BASE = 16,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output logic                    imem_req,
    output logic [PC_W-1:0]         imem_addr,
    input  logic                    imem_ack,
    input  logic [31:0]             imem_data,
    input  logic                    reg_load,
    input  logic [NREGS*DATA_W-1:0] reg_load_data,
    output logic [PC_W-1:0]         pc,
    output logic [3:0]              control,
    output logic [31:0]             instruction,
    output logic [NREGS*DATA_W-1:0] reg_flat,
    output logic [DATA_W-1:0]       write_data,
    output logic [CNT_W-1:0]        retired,
    output logic                    illegal
);

    localparam int IDX_W = $clog2(NREGS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
`ifdef MIPS_CORE_BEQ_EN
    localparam logic [5:0] OP_BEQ   = 6'h04;
`endif
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;

    // control word bit order: {jump, reg_write, branch, rtype}
    localparam logic [3:0] CTL_J     = 4'b1000;
    localparam logic [3:0] CTL_RTYPE = 4'b0101;
`ifdef MIPS_CORE_BEQ_EN
    localparam logic [3:0] CTL_BEQ   = 4'b0010;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t state;

    logic [DATA_W-1:0] regs [NREGS];
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rs_f;
    logic [4:0]        rt_f;
    logic [4:0]        rd_f;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        dec_control;
    logic              dec_illegal;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   pc_target;
`ifdef MIPS_CORE_BEQ_EN
    logic              beq_taken;
`endif

    // Architectural register numbers outside the physical window read as zero
    // and swallow writes.
    function automatic logic in_range(input logic [4:0] r);
        return (32'(r) >= 32'(REG_BASE)) && (32'(r) < 32'(REG_BASE + NREGS));
    endfunction

    function automatic logic [IDX_W-1:0] reg_idx(input logic [4:0] r);
        logic [31:0] off;
        off = 32'(r) - 32'(REG_BASE);
        return off[IDX_W-1:0];
    endfunction

    assign opcode    = instruction[31:26];
    assign rs_f      = instruction[25:21];
    assign rt_f      = instruction[20:16];
    assign rd_f      = instruction[15:11];
    assign funct     = instruction[5:0];
    assign imem_addr = pc;
    assign pc_plus4  = pc + PC_W'(4);
    // Jump target and truncated branch offset share the same low instruction bits.
    assign pc_target = {instruction[PC_W-3:0], 2'b00};

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign reg_flat[g*DATA_W +: DATA_W] = regs[g];
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        rs_val = '0;
        rt_val = '0;
        if (in_range(rs_f)) rs_val = regs[reg_idx(rs_f)];
        if (in_range(rt_f)) rt_val = regs[reg_idx(rt_f)];
    end

    always_comb begin
        alu_result = '0;
        case (funct)
            FN_ADD:  alu_result = rs_val + rt_val;
            FN_SUB:  alu_result = rs_val - rt_val;
            FN_AND:  alu_result = rs_val & rt_val;
            FN_OR:   alu_result = rs_val | rt_val;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        dec_control = 4'b0000;
        dec_illegal = 1'b1;
        case (opcode)
            OP_J: begin
                dec_control = CTL_J;
                dec_illegal = 1'b0;
            end
            OP_RTYPE: begin
                if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND || funct == FN_OR) begin
                    dec_control = CTL_RTYPE;
                    dec_illegal = 1'b0;
                end
            end
`ifdef MIPS_CORE_BEQ_EN
            OP_BEQ: begin
                dec_control = CTL_BEQ;
                dec_illegal = 1'b0;
            end
`endif
            default: begin
                dec_control = 4'b0000;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // NOTE: all state and registered outputs update with <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            control     <= '0;
            instruction <= '0;
            write_data  <= '0;
            retired     <= '0;
            illegal     <= 1'b0;
            imem_req    <= 1'b0;
            // NOTE: the register file is cleared on reset, so it must stay in flops, not a RAM macro.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef MIPS_CORE_BEQ_EN
            beq_taken   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (reg_load) begin
                        for (int i = 0; i < NREGS; i++) regs[i] <= reg_load_data[i*DATA_W +: DATA_W];
                    end
                    if (enable) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instruction <= imem_data;
                        imem_req    <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    control <= dec_control;
                    if (dec_illegal) illegal <= 1'b1;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (control[0]) write_data <= alu_result;
`ifdef MIPS_CORE_BEQ_EN
                    beq_taken <= (rs_val == rt_val);
`endif
                    state <= S_WB;
                end
                S_WB: begin
                    if (control[2] && in_range(rd_f)) regs[reg_idx(rd_f)] <= write_data;
                    retired <= retired + CNT_W'(1);
                    if (control[3]) begin
                        pc <= pc_target;
`ifdef MIPS_CORE_BEQ_EN
                    end else if (control[1] && beq_taken) begin
                        pc <= pc_plus4 + pc_target;
`endif
                    end else begin
                        pc <= pc_plus4;
                    end
                    // Fetch of the next instruction starts only once this one has retired.
                    if (enable) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: directed table, hand-written multi-cycle
// sequences and a randomized program run against a behavioural instruction-level model.
module tb_mips_multicycle_core;

    localparam int DATA_W   = 32;
    localparam int PC_W     = 4;
    localparam int NREGS    = 4;
    localparam int REG_BASE = 16;
    localparam int CNT_W    = 8;
    localparam int PC_MOD   = 2 ** PC_W;
    localparam int NWORDS   = PC_MOD / 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    enable = 1'b0;
    logic                    imem_req;
    logic [PC_W-1:0]         imem_addr;
    logic                    imem_ack = 1'b0;
    logic [31:0]             imem_data = 32'd0;
    logic                    reg_load = 1'b0;
    logic [NREGS*DATA_W-1:0] reg_load_data = '0;
    logic [PC_W-1:0]         pc;
    logic [3:0]              control;
    logic [31:0]             instruction;
    logic [NREGS*DATA_W-1:0] reg_flat;
    logic [DATA_W-1:0]       write_data;
    logic [CNT_W-1:0]        retired;
    logic                    illegal;

    mips_multicycle_core #(
        .DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS), .REG_BASE(REG_BASE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .reg_load(reg_load), .reg_load_data(reg_load_data),
        .pc(pc), .control(control), .instruction(instruction), .reg_flat(reg_flat),
        .write_data(write_data), .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Instruction memory responder with programmable ack latency (-1 = random 0..3).
    logic [31:0]     rom [NWORDS];
    int              lat_mode = 0;
    int              cur_lat = 0;
    int              wait_cnt = 0;
    bit              spurious_en = 1'b0;
    int              addr_unstable = 0;
    logic [PC_W-1:0] req_addr = '0;
    logic [PC_W-1:0] fetch_log [$];

    always @(negedge clk) begin
        if (imem_req !== 1'b1) begin
            wait_cnt  = 0;
            cur_lat   = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            imem_ack  = spurious_en && ($urandom_range(0, 1) == 1);
            imem_data = $urandom;
        end else begin
            if (wait_cnt == 0) req_addr = imem_addr;
            else if (imem_addr !== req_addr) addr_unstable++;
            if (wait_cnt >= cur_lat) begin
                imem_ack  = 1'b1;
                imem_data = rom[imem_addr[PC_W-1:2]];
                fetch_log.push_back(imem_addr);
            end else begin
                imem_ack = 1'b0;
            end
            wait_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        reg_load = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic preload(input logic [NREGS*DATA_W-1:0] d);
        @(negedge clk);
        reg_load = 1'b1;
        reg_load_data = d;
        @(negedge clk);
        reg_load = 1'b0;
    endtask

    task automatic wait_retire(input logic [CNT_W-1:0] target, input string name);
        int n;
        n = 0;
        while (retired !== target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_retire_wait"}, 128'(retired), 128'(target));
    endtask

    // ---------------- behavioural model (instruction-level) ----------------
    logic [31:0]      m_regs [NREGS];
    int               m_pc;
    logic [31:0]      m_wd;
    logic [31:0]      m_instr;
    logic [3:0]       m_ctl;
    logic             m_ill;
    logic [CNT_W-1:0] m_ret;

    function automatic logic [31:0] mread(input int r);
        if (r >= REG_BASE && r < REG_BASE + NREGS) return m_regs[r-REG_BASE];
        return 32'd0;
    endfunction

    function automatic logic [NREGS*DATA_W-1:0] mpack();
        logic [NREGS*DATA_W-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i*DATA_W +: DATA_W] = m_regs[i];
        return v;
    endfunction

    task automatic model_step(input logic [31:0] w);
        int op, rs, rt, rd, fn, nxt, off;
        logic [31:0] a, b;
        op = int'(w[31:26]);
        rs = int'(w[25:21]);
        rt = int'(w[20:16]);
        rd = int'(w[15:11]);
        fn = int'(w[5:0]);
        a = mread(rs);
        b = mread(rt);
        off = int'($signed(w[15:0])) * 4;
        nxt = (m_pc + 4) % PC_MOD;
        m_instr = w;
        if (op == 2) begin
            m_ctl = 4'b1000;
            nxt = int'(w % 32'(NWORDS)) * 4;
        end else if (op == 0 && (fn == 32 || fn == 34 || fn == 36 || fn == 37)) begin
            m_ctl = 4'b0101;
            if (fn == 32) m_wd = a + b;
            else if (fn == 34) m_wd = a - b;
            else if (fn == 36) m_wd = a & b;
            else m_wd = a | b;
            if (rd >= REG_BASE && rd < REG_BASE + NREGS) m_regs[rd-REG_BASE] = m_wd;
`ifdef MIPS_CORE_BEQ_EN
        end else if (op == 4) begin
            m_ctl = 4'b0010;
            if (a == b) nxt = (((m_pc + 4 + off) % PC_MOD) + PC_MOD) % PC_MOD;
`endif
        end else begin
            m_ctl = 4'b0000;
            m_ill = 1'b1;
        end
        m_pc = nxt;
        m_ret = m_ret + CNT_W'(1);
    endtask

    function automatic logic [31:0] gen_instr();
        int k, rs, rt;
        k  = int'($urandom_range(0, 9));
        rs = int'($urandom_range(14, 21));
        rt = int'($urandom_range(14, 21));
        case (k)
            0, 1, 2, 3, 4: begin
                case ($urandom_range(0, 3))
                    0: return rtype(rs, rt, int'($urandom_range(14, 21)), 32);
                    1: return rtype(rs, rt, int'($urandom_range(14, 21)), 34);
                    2: return rtype(rs, rt, int'($urandom_range(14, 21)), 36);
                    default: return rtype(rs, rt, int'($urandom_range(14, 21)), 37);
                endcase
            end
            5: return rtype(rs, rt, int'($urandom_range(14, 21)), int'($urandom_range(0, 63)));
            6: return {6'd2, 26'($urandom)};
            7: return {6'd4, 5'(rs), 5'(($urandom_range(0, 1) == 1) ? rs : rt), 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  ctl;
        logic [31:0] wd;
        logic        ill;
        logic [3:0]  npc;
        int          ridx;
        logic [31:0] rval;
    } vec_t;

    vec_t vecs [$];

    task automatic add_vec(input string n, input logic [31:0] i, input logic [3:0] c, input logic [31:0] wd,
                           input logic il, input logic [3:0] p, input int ri, input logic [31:0] rv);
        vec_t v;
        v.name = n; v.instr = i; v.ctl = c; v.wd = wd; v.ill = il; v.npc = p; v.ridx = ri; v.rval = rv;
        vecs.push_back(v);
    endtask

    // $s0=1, $s1=111, $s2=27, $s3=3 (index 0 in LSBs)
    localparam logic [127:0] PRELOAD = {32'd3, 32'd27, 32'd111, 32'd1};

    task automatic run_program(input int lat, input string tag);
        int c1, c2, c3;
        logic [11:0] fl;
        do_reset();
        preload(PRELOAD);
        rom[0] = 32'h08000002;
        rom[1] = 32'h02508020;
        rom[2] = 32'h02118020;
        rom[3] = 32'h02328020;
        fetch_log.delete();
        addr_unstable = 0;
        lat_mode = lat;
        @(negedge clk);
        enable = 1'b1;
        wait_retire(1, tag);
        c1 = cyc;
        check({tag, "_ctl_j"}, 128'(control), 128'(4'b1000));
        check({tag, "_pc_j"}, 128'(pc), 128'(8));
        wait_retire(2, tag);
        c2 = cyc;
        enable = 1'b0;
        check({tag, "_ctl_add1"}, 128'(control), 128'(4'b0101));
        check({tag, "_regs_add1"}, 128'(reg_flat), {32'd3, 32'd27, 32'd111, 32'd112});
        check({tag, "_pc_add1"}, 128'(pc), 128'(12));
        wait_retire(3, tag);
        c3 = cyc;
        check({tag, "_regs_add2"}, 128'(reg_flat), {32'd3, 32'd27, 32'd111, 32'd138});
        check({tag, "_pc_wrap"}, 128'(pc), 128'(0));
        check({tag, "_cpi_a"}, 128'(c2 - c1), 128'(lat + 4));
        check({tag, "_cpi_b"}, 128'(c3 - c2), 128'(lat + 4));
        repeat (lat + 6) @(negedge clk);
        check({tag, "_halted_req"}, 128'(imem_req), 128'(0));
        check({tag, "_halted_retired"}, 128'(retired), 128'(3));
        fl = '1;
        if (fetch_log.size() == 3) fl = {fetch_log[0], fetch_log[1], fetch_log[2]};
        check({tag, "_fetch_order"}, 128'(fl), 128'({4'd0, 4'd8, 4'd12}));
        check({tag, "_addr_stable"}, 128'(addr_unstable), 128'(0));
    endtask

    initial begin
        logic [NREGS*DATA_W-1:0] d;
        logic [31:0] w;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_pc", 128'(pc), 128'(0));
        check("rst_req", 128'(imem_req), 128'(0));
        check("rst_regs", 128'(reg_flat), 128'(0));
        check("rst_misc", 128'({control, instruction, write_data, retired, illegal}), 128'(0));

        // Single-instruction table
        add_vec("add", rtype(17, 18, 16, 32), 4'b0101, 32'd138, 1'b0, 4'd4, 0, 32'd138);
        add_vec("sub_wrap", rtype(16, 17, 19, 34), 4'b0101, 32'hFFFF_FF92, 1'b0, 4'd4, 3, 32'hFFFF_FF92);
        add_vec("and", rtype(17, 19, 18, 36), 4'b0101, 32'd3, 1'b0, 4'd4, 2, 32'd3);
        add_vec("or", rtype(16, 18, 17, 37), 4'b0101, 32'd27, 1'b0, 4'd4, 1, 32'd27);
        add_vec("rd_out_of_range", rtype(17, 18, 8, 32), 4'b0101, 32'd138, 1'b0, 4'd4, 0, 32'd1);
        add_vec("rs_out_of_range", rtype(0, 19, 16, 32), 4'b0101, 32'd3, 1'b0, 4'd4, 0, 32'd3);
        add_vec("bad_funct", rtype(16, 17, 16, 33), 4'b0000, 32'd0, 1'b1, 4'd4, 0, 32'd1);
        add_vec("bad_opcode", 32'hFC00_0000, 4'b0000, 32'd0, 1'b1, 4'd4, 0, 32'd1);
        add_vec("jump", 32'h0800_0003, 4'b1000, 32'd0, 1'b0, 4'd12, 0, 32'd1);
`ifdef MIPS_CORE_BEQ_EN
        add_vec("beq_taken", 32'h1210_FFFE, 4'b0010, 32'd0, 1'b0, 4'd12, 0, 32'd1);
`else
        add_vec("beq_unsupported", 32'h1210_FFFE, 4'b0000, 32'd0, 1'b1, 4'd4, 0, 32'd1);
`endif
        lat_mode = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            preload(PRELOAD);
            rom[0] = vecs[i].instr;
            @(negedge clk);
            enable = 1'b1;
            @(negedge clk);
            enable = 1'b0;
            wait_retire(1, vecs[i].name);
            check({vecs[i].name, "_ctl"}, 128'(control), 128'(vecs[i].ctl));
            check({vecs[i].name, "_wd"}, 128'(write_data), 128'(vecs[i].wd));
            check({vecs[i].name, "_illegal"}, 128'(illegal), 128'(vecs[i].ill));
            check({vecs[i].name, "_pc"}, 128'(pc), 128'(vecs[i].npc));
            check({vecs[i].name, "_reg"}, 128'(reg_flat[vecs[i].ridx*DATA_W +: DATA_W]), 128'(vecs[i].rval));
        end

        // Program with immediate and slow ack
        run_program(0, "prog_fast");
        run_program(5, "prog_slow");
        lat_mode = 0;

        // beq at pc=8 reached through a jump
        do_reset();
        preload(PRELOAD);
        rom[0] = 32'h0800_0002;
        rom[2] = 32'h1210_FFFE;
        @(negedge clk);
        enable = 1'b1;
        wait_retire(1, "beq_seq");
        enable = 1'b0;
        wait_retire(2, "beq_seq");
`ifdef MIPS_CORE_BEQ_EN
        check("beq_seq_pc", 128'(pc), 128'(4));
        check("beq_seq_illegal", 128'(illegal), 128'(0));
`else
        check("beq_seq_pc", 128'(pc), 128'(12));
        check("beq_seq_illegal", 128'(illegal), 128'(1));
`endif

        // Sticky illegal, then reset in the middle of EXEC
        do_reset();
        preload(PRELOAD);
        rom[0] = 32'hFC00_0000;
        rom[1] = rtype(17, 18, 16, 32);
        rom[2] = rtype(17, 18, 16, 32);
        @(negedge clk);
        enable = 1'b1;
        wait_retire(1, "sticky");
        enable = 1'b0;
        wait_retire(2, "sticky");
        check("sticky_illegal", 128'(illegal), 128'(1));
        check("sticky_ctl", 128'(control), 128'(4'b0101));
        check("sticky_pc", 128'(pc), 128'(8));
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midexec_rst_pc", 128'(pc), 128'(0));
        check("midexec_rst_req", 128'(imem_req), 128'(0));
        check("midexec_rst_regs", 128'(reg_flat), 128'(0));
        check("midexec_rst_misc", 128'({control, instruction, write_data, retired, illegal}), 128'(0));
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("midexec_idle_req", 128'(imem_req), 128'(0));
        check("midexec_idle_retired", 128'(retired), 128'(0));

        // Randomized runs against the model; retired wraps past 2**CNT_W
        do_reset();
        m_pc = 0; m_wd = '0; m_instr = '0; m_ctl = '0; m_ill = 1'b0; m_ret = '0;
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < NWORDS; i++) rom[i] = gen_instr();
            for (int i = 0; i < NREGS; i++) begin
                d[i*DATA_W +: DATA_W] = $urandom;
                m_regs[i] = d[i*DATA_W +: DATA_W];
            end
            preload(d);
            lat_mode = -1;
            spurious_en = 1'b1;
            @(negedge clk);
            enable = 1'b1;
            @(negedge clk);
            reg_load = 1'b1;
            reg_load_data = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 40; k++) begin
                w = rom[m_pc / 4];
                wait_retire(m_ret + CNT_W'(1), "rnd");
                model_step(w);
                check("rnd_pc", 128'(pc), 128'(m_pc));
                check("rnd_regs", 128'(reg_flat), 128'(mpack()));
                check("rnd_wd", 128'(write_data), 128'(m_wd));
                check("rnd_ctl", 128'(control), 128'(m_ctl));
                check("rnd_illegal", 128'(illegal), 128'(m_ill));
                check("rnd_instr", 128'(instruction), 128'(m_instr));
                if (k == 38) begin
                    enable = 1'b0;
                    reg_load = 1'b0;
                end
            end
            repeat (6) @(negedge clk);
            check("rnd_halted_req", 128'(imem_req), 128'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
